rfg_axis_io_arbiter: RTL and testbench
======================================

Name: rfg_axis_io_arbiter

Overview:
- Frame-aware N:1 arbiter that merges byte streams from several I/O interfaces (UART, SPI, USB bridges) into the single AXIS slave of the RFG protocol processor.
- Tags each forwarded byte with the source port index on tid.
- Parses the RFG frame format so that a port keeps the grant for a whole frame, and frames from different ports are never interleaved.
- Routes readback bytes coming out of the protocol processor back to the port selected by tdest.

Parameters:
N_PORTS, 2, number of I/O ports (1..8)
DATA_WIDTH, 8, byte width (fixed 8)
ID_DEST_WIDTH, 8, width of tid/tdest

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
s_axis_tdata  in  N_PORTS*8  I/O port bytes, port i at [8i+7:8i]
s_axis_tvalid  in  N_PORTS  per-port valid
s_axis_tready  out  N_PORTS  per-port ready
m_axis_tdata  out  8  to protocol processor
m_axis_tvalid  out  1  valid
m_axis_tready  in  1  ready
m_axis_tid  out  ID_DEST_WIDTH  granted port index, zero-extended
s_ret_axis_tdata  in  8  readback bytes from protocol processor
s_ret_axis_tvalid  in  1  valid
s_ret_axis_tready  out  1  ready
s_ret_axis_tlast  in  1  last
s_ret_axis_tdest  in  ID_DEST_WIDTH  destination port
m_ret_axis_tdata  out  N_PORTS*8  readback per port
m_ret_axis_tvalid  out  N_PORTS  valid
m_ret_axis_tready  in  N_PORTS  ready
m_ret_axis_tlast  out  N_PORTS  last
debug_grant  out  3  current grant index
debug_state  out  3  parser state

Behaviour:
- Single clock domain: aclk. Reset is synchronous and active-high on areset.
- Reset values:
  - state=IDLE, grant=0, rr_ptr=0.
  - All s_axis_tready=0, m_axis_tvalid=0, m_axis_tid=0.
  - debug outputs 0.
  - Return path is combinational, so m_ret_axis_tvalid follows s_ret_axis_tvalid during reset.
- Reset mid-frame: the parser drops to IDLE on the next edge and any partial frame is abandoned.
- Arbitration:
  - In IDLE, pick the first port with tvalid=1, scanning round-robin from rr_ptr.
  - Register the grant and go to HDR. No byte is accepted in IDLE, so there is one cycle of arbitration latency.
  - At frame end, set rr_ptr = grant+1, wrapping modulo N_PORTS.
- Forward path (combinational from the registered grant):
  - m_axis_tdata/tvalid come from the granted port.
  - s_axis_tready[grant] = m_axis_tready when state != IDLE. All other readies are 0.
  - A beat is accepted when tvalid && tready on the granted port. The parser advances only on accepted beats.
- Parser states:
  - HDR:
    - Latch wr=bit0, rd=bit1, ext=bit3.
    - If wr=0 and rd=0, this is a 1-byte frame: end.
    - Otherwise go to ADDRA.
  - ADDRA: go to ADDRB if ext, else LENA.
  - ADDRB: go to LENA.
  - LENA: latch length[7:0]; go to LENB.
  - LENB:
    - Latch length[15:8].
    - If wr, load cnt=length and go to PAYLOAD. Write takes priority when wr and rd are both set.
    - Otherwise (read) the frame ends.
  - PAYLOAD:
    - cnt decrements per accepted beat; the frame ends on the beat where cnt==1.
    - cnt is 16-bit. length=0 means 65536 payload bytes: 0 wraps to 0xFFFF, which matches downstream counting.
  - Frame end: on the accepted last beat, go to IDLE. The next grant is decided the cycle after.
- Stalls:
  - If the granted port deasserts tvalid mid-frame, hold the grant indefinitely.
  - Other ports stay stalled; no timeout.
- Return path (combinational):
  - If tdest < N_PORTS: m_ret_axis_tvalid[tdest] = s_ret_axis_tvalid, and tdata/tlast are broadcast to all ports. s_ret_axis_tready = m_ret_axis_tready[tdest].
  - If tdest >= N_PORTS: s_ret_axis_tready=1 and the byte is dropped.
  - Unselected ports have tvalid=0.
- Forward and return paths are independent. Simultaneous activity is allowed.

Test Plan:
1. Port0 sends write frame 01 10 02 00 AA BB -> m_axis carries the same 6 bytes with tid=0. FSM returns to IDLE after BB. s_axis_tready[1]=0 throughout.
2. Port1 sends extended read frame 0A 34 12 04 00 -> 5 bytes forwarded with tid=1. Frame ends on the 5th byte; port1 is not granted again until it presents another header.
3. Ports 0 and 1 both present write frames of length 3 on the same cycle, rr_ptr=0 -> all 8 port0 bytes pass first, then all 8 port1 bytes with tid=1. No interleaving. rr_ptr ends at 0.
4. Port0 sends null header 00 followed by 01 05 01 00 77 -> 00 is treated as a complete 1-byte frame. Re-arbitration (IDLE cycle) occurs. The second frame is forwarded intact.
5. m_axis_tready toggles 1,0,0,1 during a payload -> no byte is lost or duplicated. cnt decrements only on accepted beats.
6. Return stream with tdest=1 sends bytes 55,66 (tlast on 66) while m_ret_axis_tready[1]=0 for 2 cycles -> bytes appear only on port1 and backpressure propagates. A byte with tdest=5 and N_PORTS=2 is consumed with s_ret_axis_tready=1 and appears on no port.

Source files
------------

// File: rtl/rfg_axis_io_arbiter.sv
// rfg_axis_io_arbiter: frame-aware N:1 AXIS arbiter with tid tagging and tdest-routed readback
module rfg_axis_io_arbiter #(
    parameter int N_PORTS       = 2,
    parameter int DATA_WIDTH    = 8,
    parameter int ID_DEST_WIDTH = 8
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [N_PORTS-1:0]              s_axis_tvalid,
    output logic [N_PORTS-1:0]              s_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [ID_DEST_WIDTH-1:0]        m_axis_tid,
    input  logic [DATA_WIDTH-1:0]           s_ret_axis_tdata,
    input  logic                            s_ret_axis_tvalid,
    output logic                            s_ret_axis_tready,
    input  logic                            s_ret_axis_tlast,
    input  logic [ID_DEST_WIDTH-1:0]        s_ret_axis_tdest,
    output logic [N_PORTS*DATA_WIDTH-1:0]   m_ret_axis_tdata,
    output logic [N_PORTS-1:0]              m_ret_axis_tvalid,
    input  logic [N_PORTS-1:0]              m_ret_axis_tready,
    output logic [N_PORTS-1:0]              m_ret_axis_tlast,
    output logic [2:0]                      debug_grant,
    output logic [2:0]                      debug_state
);
    typedef enum logic [2:0] {IDLE, HDR, ADDRA, ADDRB, LENA, LENB, PAYLOAD} state_t;
    state_t        state;
    logic [2:0]    grant, rr_ptr, pick, rr_next;
    logic          found, g_valid, acc, last, wr, ext;
    logic [7:0]    len_lo;
    logic [15:0]   cnt;

    // round-robin search: lowest rotation distance from rr_ptr wins
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = N_PORTS - 1; i >= 0; i--)
            for (int k = 0; k < N_PORTS; k++)
                if (k == (int'(rr_ptr) + i) % N_PORTS && s_axis_tvalid[k]) begin
                    pick  = 3'(k);
                    found = 1'b1;
                end
    end

    // forward mux and ready steering from the registered grant
    always_comb begin
        m_axis_tdata  = '0;
        g_valid       = 1'b0;
        s_axis_tready = '0;
        for (int k = 0; k < N_PORTS; k++)
            if (grant == 3'(k)) begin
                m_axis_tdata     = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                g_valid          = s_axis_tvalid[k];
                s_axis_tready[k] = state != IDLE && m_axis_tready;
            end
    end

    assign m_axis_tvalid = state != IDLE && g_valid;
    assign acc           = m_axis_tvalid && m_axis_tready;
    assign last          = acc && ((state == HDR && ~|m_axis_tdata[1:0]) ||
                                   (state == LENB && !wr) ||
                                   (state == PAYLOAD && cnt == 16'd1));
    assign rr_next       = grant == 3'(N_PORTS - 1) ? 3'd0 : grant + 3'd1;
    assign m_axis_tid    = ID_DEST_WIDTH'(grant);
    assign debug_grant   = grant;
    assign debug_state   = state;

    // frame parser: holds the grant until the accepted last beat of a frame
    always_ff @(posedge aclk) begin
        if (areset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            wr     <= 1'b0;
            ext    <= 1'b0;
            len_lo <= '0;
            cnt    <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                grant <= pick;
                state <= HDR;
            end
        end else if (acc) begin
            if (state == HDR) begin
                wr  <= m_axis_tdata[0];
                ext <= m_axis_tdata[3];
            end
            if (state == LENA) len_lo <= m_axis_tdata;
            cnt    <= state == LENB ? {m_axis_tdata, len_lo} : state == PAYLOAD ? cnt - 16'd1 : cnt;
            state  <= last ? IDLE : state == HDR ? ADDRA : state == ADDRA ? (ext ? ADDRB : LENA) :
                      state == ADDRB ? LENA : state == LENA ? LENB : PAYLOAD;
            if (last) rr_ptr <= rr_next;
        end
    end

    // readback routing: out-of-range tdest is consumed and dropped
    always_comb begin
        m_ret_axis_tvalid = '0;
        s_ret_axis_tready = 1'b1;
        for (int k = 0; k < N_PORTS; k++)
            if (32'(s_ret_axis_tdest) == k) begin
                m_ret_axis_tvalid[k] = s_ret_axis_tvalid;
                s_ret_axis_tready    = m_ret_axis_tready[k];
            end
    end

    assign m_ret_axis_tdata = {N_PORTS{s_ret_axis_tdata}};
    assign m_ret_axis_tlast = {N_PORTS{s_ret_axis_tlast}};
endmodule

// File: tb/tb_rfg_axis_io_arbiter.sv
// tb_rfg_axis_io_arbiter: scoreboard bench for the frame-aware I/O arbiter
module tb_rfg_axis_io_arbiter;
    logic        aclk = 1'b0;
    logic        areset;
    logic [15:0] s_axis_tdata;
    logic [1:0]  s_axis_tvalid;
    logic [1:0]  s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [7:0]  m_axis_tid;
    logic [7:0]  s_ret_axis_tdata;
    logic        s_ret_axis_tvalid;
    logic        s_ret_axis_tready;
    logic        s_ret_axis_tlast;
    logic [7:0]  s_ret_axis_tdest;
    logic [15:0] m_ret_axis_tdata;
    logic [1:0]  m_ret_axis_tvalid;
    logic [1:0]  m_ret_axis_tready;
    logic [1:0]  m_ret_axis_tlast;
    logic [2:0]  debug_grant;
    logic [2:0]  debug_state;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  pq0[$], pq1[$];
    logic [15:0] exp_q[$];
    logic [16:0] ret_q[$];

    rfg_axis_io_arbiter #(.N_PORTS(2), .DATA_WIDTH(8), .ID_DEST_WIDTH(8)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tid(m_axis_tid),
        .s_ret_axis_tdata(s_ret_axis_tdata), .s_ret_axis_tvalid(s_ret_axis_tvalid),
        .s_ret_axis_tready(s_ret_axis_tready), .s_ret_axis_tlast(s_ret_axis_tlast),
        .s_ret_axis_tdest(s_ret_axis_tdest),
        .m_ret_axis_tdata(m_ret_axis_tdata), .m_ret_axis_tvalid(m_ret_axis_tvalid),
        .m_ret_axis_tready(m_ret_axis_tready), .m_ret_axis_tlast(m_ret_axis_tlast),
        .debug_grant(debug_grant), .debug_state(debug_state)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // frame f holds n bytes, first byte most significant
    task automatic send_frame(input int p, input int n, input logic [63:0] f);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = f[(n-1-i)*8 +: 8];
            if (p == 0) pq0.push_back(b); else pq1.push_back(b);
            exp_q.push_back({8'(p), b});
        end
    endtask

    task automatic step;
        @(posedge aclk); #1;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        do begin
            @(negedge aclk);
            k++;
        end while (!(pq0.size() == 0 && pq1.size() == 0 && exp_q.size() == 0 && debug_state == 3'd0) && k < 300);
        chk(name, 32'({exp_q.size() == 0, debug_state}), 32'({1'b1, 3'd0}));
        step();
    endtask

    // port drivers: present queue heads, pop on handshake seen at the previous negedge
    initial begin
        logic [1:0] fire;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        forever begin
            @(negedge aclk);
            fire = s_axis_tvalid & s_axis_tready;
            @(posedge aclk); #1;
            if (fire[0]) void'(pq0.pop_front());
            if (fire[1]) void'(pq1.pop_front());
            s_axis_tvalid = {pq1.size() > 0, pq0.size() > 0};
            s_axis_tdata  = {pq1.size() > 0 ? pq1[0] : 8'h00, pq0.size() > 0 ? pq0[0] : 8'h00};
        end
    end

    // forward monitor
    always @(negedge aclk) begin
        if (!areset && debug_state == 3'd0) chk("idle_ready", 32'(s_axis_tready), 32'd0);
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) chk("fwd_unexpected", {16'd0, m_axis_tid, m_axis_tdata}, 32'hFFFF_FFFF);
            else begin
                chk("fwd_beat", 32'({m_axis_tid, m_axis_tdata}), 32'(exp_q.pop_front()));
                chk("fwd_ready_onehot", 32'(s_axis_tready), m_axis_tid == 8'd0 ? 32'd1 : 32'd2);
            end
        end
    end

    // return monitor
    always @(negedge aclk) begin
        if (!areset && m_ret_axis_tvalid != 2'b00) chk("ret_onehot", 32'($onehot(m_ret_axis_tvalid)), 32'd1);
        for (int p = 0; p < 2; p++)
            if (!areset && m_ret_axis_tvalid[p] && m_ret_axis_tready[p]) begin
                if (ret_q.size() == 0) chk("ret_unexpected", 32'(p), 32'hFFFF_FFFF);
                else chk("ret_beat", 32'({8'(p), m_ret_axis_tdata[p*8 +: 8], m_ret_axis_tlast[p]}),
                         32'(ret_q.pop_front()));
            end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        areset            = 1'b1;
        m_axis_tready     = 1'b1;
        s_ret_axis_tvalid = 1'b1;
        s_ret_axis_tdest  = 8'd0;
        s_ret_axis_tdata  = 8'h11;
        s_ret_axis_tlast  = 1'b0;
        m_ret_axis_tready = 2'b00;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_s_ready", 32'(s_axis_tready), 32'd0);
        chk("rst_m_valid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tid", 32'(m_axis_tid), 32'd0);
        chk("rst_dbg", 32'({debug_grant, debug_state}), 32'd0);
        chk("rst_ret_valid", 32'(m_ret_axis_tvalid), 32'd1);
        step();
        areset            = 1'b0;
        s_ret_axis_tvalid = 1'b0;

        send_frame(0, 6, 64'h0110_0200_AABB);
        wait_idle("t1_write_p0");

        send_frame(1, 5, 64'h0A_3412_0400);
        wait_idle("t2_ext_read_p1");
        repeat (3) begin
            @(negedge aclk);
            chk("t2_no_regrant", 32'(debug_state), 32'd0);
        end
        step();

        send_frame(0, 8, 64'h09_10_20_03_00_A1_A2_A3);
        send_frame(1, 8, 64'h09_11_21_03_00_B1_B2_B3);
        wait_idle("t3_both_ports");
        send_frame(0, 1, 64'h00);
        send_frame(1, 1, 64'h00);
        wait_idle("t3_rr_back_to_p0");

        send_frame(0, 6, 64'h00_01_05_01_00_77);
        begin
            int k = 0;
            do begin
                @(negedge aclk);
                k++;
            end while (debug_state != 3'd1 && k < 20);
            chk("t4_reach_hdr", 32'(debug_state), 32'd1);
            @(negedge aclk);
            chk("t4_idle_gap", 32'({debug_state, m_axis_tvalid}), 32'd0);
        end
        wait_idle("t4_null_hdr");

        send_frame(0, 8, 64'h01_10_04_00_D1_D2_D3_D4);
        for (int i = 0; i < 24; i++) begin
            m_axis_tready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        m_axis_tready = 1'b1;
        wait_idle("t5_backpressure");

        m_ret_axis_tready = 2'b00;
        s_ret_axis_tvalid = 1'b1;
        s_ret_axis_tdest  = 8'd1;
        s_ret_axis_tdata  = 8'h55;
        s_ret_axis_tlast  = 1'b0;
        ret_q.push_back({8'd1, 8'h55, 1'b0});
        repeat (2) begin
            @(negedge aclk);
            chk("t6_stall", 32'({s_ret_axis_tready, m_ret_axis_tvalid}), 32'b010);
            step();
        end
        m_ret_axis_tready = 2'b10;
        @(negedge aclk);
        chk("t6_ready", 32'(s_ret_axis_tready), 32'd1);
        step();
        s_ret_axis_tdata = 8'h66;
        s_ret_axis_tlast = 1'b1;
        ret_q.push_back({8'd1, 8'h66, 1'b1});
        step();
        m_ret_axis_tready = 2'b00;
        s_ret_axis_tdest  = 8'd5;
        s_ret_axis_tdata  = 8'h99;
        s_ret_axis_tlast  = 1'b0;
        @(negedge aclk);
        chk("t6_drop", 32'({s_ret_axis_tready, m_ret_axis_tvalid}), 32'b100);
        step();
        s_ret_axis_tvalid = 1'b0;
        @(negedge aclk);
        chk("t6_ret_drained", 32'(ret_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
